noc_local_injector: RTL

Network-interface injector sitting directly upstream of a mesh router's local input port. It accepts a packet request plus a stream of payload words from the attached core and serializes them into header/body/tail flits on `local_in` with `push_local`. It meters injection with a credit counter tracking the router's local input FIFO. Credits return on the router's `pop_local`.

---
 rtl/noc_local_injector.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/noc_local_injector.sv
// Local-port injector: turns core packet requests into header/body/tail flits, metered by router credits.
// Define NOC_INJ_SEQ_EN to stamp an 8-bit wrapping sequence number into header bits [17:10].
module noc_local_injector #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  routeridx,
    input  logic [1:0]  routeridy,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [1:0]  pkt_dst_x,
    input  logic [1:0]  pkt_dst_y,
    input  logic [3:0]  pkt_len,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [29:0] data_in,
    output logic [31:0] local_in,
    output logic        push_local,
    input  logic        pop_local,
    output logic        busy,
    output logic        credit_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEAD    = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [2:0] CREDIT_MAX = 3'(FIFO_DEPTH);

    logic [1:0]  state_q, state_d;
    logic [1:0]  src_x_q, src_x_d;
    logic [1:0]  src_y_q, src_y_d;
    logic [1:0]  dst_x_q, dst_x_d;
    logic [1:0]  dst_y_q, dst_y_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  credit_q, credit_d;
    logic        err_q, err_d;
    logic [31:0] flit_q, flit_d;
    logic        push_q, push_d;
    logic [7:0]  seq_field;
    logic        have_credit;

`ifdef NOC_INJ_SEQ_EN
    logic [7:0]  seq_q, seq_d;
    assign seq_field = seq_q;
`else
    assign seq_field = 8'h00;
`endif

    assign have_credit = (credit_q != 3'd0);
    assign pkt_ready   = (state_q == ST_IDLE);
    assign data_ready  = (state_q == ST_PAYLOAD) && have_credit;
    assign busy        = (state_q != ST_IDLE);
    assign local_in    = flit_q;
    assign push_local  = push_q;
    assign credit_err  = err_q;

    always_comb begin
        state_d  = state_q;
        src_x_d  = src_x_q;
        src_y_d  = src_y_q;
        dst_x_d  = dst_x_q;
        dst_y_d  = dst_y_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        flit_d   = flit_q;
        push_d   = 1'b0;
        credit_d = credit_q;
        err_d    = err_q;
`ifdef NOC_INJ_SEQ_EN
        seq_d    = seq_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pkt_valid) begin
                    src_x_d = routeridx;
                    src_y_d = routeridy;
                    dst_x_d = pkt_dst_x;
                    dst_y_d = pkt_dst_y;
                    len_d   = pkt_len;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (have_credit) begin
                    flit_d  = {2'b01, src_x_q, src_y_q, dst_x_q, dst_y_q, len_q, seq_field, 10'b0};
                    push_d  = 1'b1;
                    cnt_d   = len_q;
                    state_d = ST_PAYLOAD;
`ifdef NOC_INJ_SEQ_EN
                    seq_d   = seq_q + 8'd1;
`endif
                end
            end
            ST_PAYLOAD: begin
                if (data_valid && have_credit) begin
                    push_d = 1'b1;
                    if (cnt_q != 4'd0) begin
                        flit_d = {2'b10, data_in};
                        cnt_d  = cnt_q - 4'd1;
                    end else begin
                        flit_d  = {2'b11, data_in};
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Credit is consumed when the flit is registered, so the next cycle already sees it.
        case ({push_d, pop_local})
            2'b10: credit_d = credit_q - 3'd1;
            2'b01: begin
                if (credit_q == CREDIT_MAX) err_d = 1'b1;
                else                        credit_d = credit_q + 3'd1;
            end
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            src_x_q  <= '0;
            src_y_q  <= '0;
            dst_x_q  <= '0;
            dst_y_q  <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            flit_q   <= '0;
            push_q   <= 1'b0;
            credit_q <= CREDIT_MAX;
            err_q    <= 1'b0;
`ifdef NOC_INJ_SEQ_EN
            seq_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            src_x_q  <= src_x_d;
            src_y_q  <= src_y_d;
            dst_x_q  <= dst_x_d;
            dst_y_q  <= dst_y_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            flit_q   <= flit_d;
            push_q   <= push_d;
            credit_q <= credit_d;
            err_q    <= err_d;
`ifdef NOC_INJ_SEQ_EN
            seq_q    <= seq_d;
`endif
        end
    end

endmodule
